tug_match_master: RTL

Match-level sequencer for the tug-of-war game. Runs a best-of match by alternating tug-of-war rounds and speed rounds, keeps both players' scores and declares the match winner. Sits above the tug round logic and the speed round controller. It drives their round-enable inputs and consumes their one-pulse round-result strobes.

---
 rtl/tug_match_master_if.sv | 35 +++
 rtl/tug_match_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tug_match_master_if.sv
// Signal bundle between the match sequencer and its surroundings (round logic, buttons, display).
// The master modport is the sequencer's view; slave is the environment's view.
interface tug_match_master_if #(
    parameter int SCORE_W = 3
);
    // Pulse semantics: tug_win and winspeed are one-cycle strobes and qualify their
    // companion bits (tug_right / speed_right, speed_tie) in that same cycle only;
    // there is no back-pressure, so a strobe outside the matching round is dropped.
    logic               slowen;
    logic               start;
    logic               tug_win;
    logic               tug_right;
    logic               winspeed;
    logic               speed_right;
    logic               speed_tie;
    logic               speed_exit;
    logic               tug_en;
    logic               speed_round;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [3:0]         round_num;
    logic               match_over;
    logic               match_right;
    logic [2:0]         dbg_state;

    modport master (
        input  slowen, start, tug_win, tug_right, winspeed, speed_right, speed_tie, speed_exit,
        output tug_en, speed_round, score_l, score_r, round_num, match_over, match_right, dbg_state
    );

    modport slave (
        output slowen, start, tug_win, tug_right, winspeed, speed_right, speed_tie, speed_exit,
        input  tug_en, speed_round, score_l, score_r, round_num, match_over, match_right, dbg_state
    );
endinterface

// File: rtl/tug_match_master.sv
// Best-of match sequencer: alternates tug and speed rounds, keeps scores, declares the winner.
// Define SPEED_ROUND_EN to interleave speed rounds; otherwise only tug rounds are played.
module tug_match_master #(
    parameter int WIN_SCORE = 3,
    parameter int SCORE_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    tug_match_master_if.master  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TUG       = 3'd1;
    localparam logic [2:0] S_TUG_GAP   = 3'd2;
`ifdef SPEED_ROUND_EN
    localparam logic [2:0] S_SPEED     = 3'd3;
    localparam logic [2:0] S_SPEED_GAP = 3'd4;
`endif
    localparam logic [2:0] S_CHECK     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    logic [2:0]         state;
    logic               start_q;
    logic [SCORE_W-1:0] score_l_q;
    logic [SCORE_W-1:0] score_r_q;
    logic [3:0]         round_q;
    logic               start_rise;
    logic               l_hit;
    logic               r_hit;

    assign start_rise = bus.start & ~start_q;
    assign l_hit      = (score_l_q >= WIN);
    assign r_hit      = (score_r_q >= WIN);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? s : s + 1'b1;
    endfunction

`ifdef SPEED_ROUND_EN
    // prev_tug picks the next round type; speed_scored drops repeat result strobes.
    logic prev_tug;
    logic speed_scored;
`else
    logic unused_speed;
    assign unused_speed = ^{bus.winspeed, bus.speed_right, bus.speed_tie, bus.speed_exit};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            round_q   <= 4'd0;
`ifdef SPEED_ROUND_EN
            prev_tug     <= 1'b0;
            speed_scored <= 1'b0;
`endif
        end else begin
            start_q <= bus.start;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_rise) begin
                        state     <= S_TUG;
                        score_l_q <= '0;
                        score_r_q <= '0;
                        round_q   <= 4'd1;
                    end
                end
                S_TUG: begin
                    if (bus.tug_win) begin
                        if (bus.tug_right) score_r_q <= sat_inc(score_r_q);
                        else               score_l_q <= sat_inc(score_l_q);
                        state <= S_TUG_GAP;
`ifdef SPEED_ROUND_EN
                        prev_tug <= 1'b1;
`endif
                    end
                end
                // A slowen in the same cycle as tug_win was seen in S_TUG, so it never counts here.
                S_TUG_GAP: begin
                    if (bus.slowen) state <= S_CHECK;
                end
`ifdef SPEED_ROUND_EN
                S_SPEED: begin
                    if (bus.winspeed && !speed_scored) begin
                        speed_scored <= 1'b1;
                        if (bus.speed_right)     score_r_q <= sat_inc(score_r_q);
                        else if (!bus.speed_tie) score_l_q <= sat_inc(score_l_q);
                    end
                    if (bus.speed_exit) begin
                        state    <= S_SPEED_GAP;
                        prev_tug <= 1'b0;
                    end
                end
                S_SPEED_GAP: begin
                    if (!bus.speed_exit) state <= S_CHECK;
                end
`endif
                S_CHECK: begin
                    if (l_hit || r_hit) begin
                        state <= S_DONE;
                    end else begin
                        if (round_q != 4'd15) round_q <= round_q + 4'd1;
`ifdef SPEED_ROUND_EN
                        if (prev_tug) begin
                            state        <= S_SPEED;
                            speed_scored <= 1'b0;
                        end else begin
                            state <= S_TUG;
                        end
`else
                        state <= S_TUG;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tug_en      = (state == S_TUG);
`ifdef SPEED_ROUND_EN
    assign bus.speed_round = (state == S_SPEED);
`else
    assign bus.speed_round = 1'b0;
`endif
    assign bus.score_l     = score_l_q;
    assign bus.score_r     = score_r_q;
    assign bus.round_num   = round_q;
    assign bus.match_over  = (state == S_DONE);
    assign bus.match_right = (state == S_DONE) && r_hit;
    assign bus.dbg_state   = state;
endmodule
